mbox_wb_master: RTL and testbench

MBOX_WB_MASTER -- requirements
Module: mbox_wb_master

---
 rtl/mbox_wb_master.sv | 138 +++++++++++++
 tb/tb_mbox_wb_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbox_wb_master.sv
// mbox_wb_master: walks a mailbox RAM slot by slot. Each pending entry is run as
// one Wishbone read or write, then written back with its pending bit cleared.
// Ports: clk/rst; scan_en gates scanning; ram_* is the mailbox port (1-cycle read
// latency); wb_* is the Wishbone master; busy/done/err report status.
// Optional build macro MBOX_WB_TIMEOUT_EN adds a TIMEOUT-cycle ack watchdog.
module mbox_wb_master #(
  parameter int SLOTS   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  output logic        ram_en,
  output logic        ram_we,
  output logic [4:0]  ram_addr,
  output logic [41:0] ram_din,
  input  logic [41:0] ram_dout,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy,
  output logic        done,
  output logic        err
);

  if (SLOTS < 1 || SLOTS > 32) begin : g_bad_slots
    $error("SLOTS must be in 1..32");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, BUS, WRBACK} state_t;

  state_t      state, state_nxt;
  logic [4:0]  slot;
  logic [41:0] entry;
  logic [31:0] result;
  logic        timed_out;  // watchdog expires in this BUS cycle
  logic        to_flag;    // current writeback is the product of a timeout

`ifdef MBOX_WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state == BUS && !wb_ack_i) to_cnt <= to_cnt + 1'b1;
      else                           to_cnt <= '0;
      // Re-evaluated every BUS cycle, so it holds the exit reason in WRBACK.
      if (state == BUS) to_flag <= timed_out;
    end
  end

  assign timed_out = (state == BUS) && !wb_ack_i && (to_cnt == TW'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
  assign to_flag   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot   <= '0;
      entry  <= '0;
      result <= '0;
    end else begin
      if (state == RD_DATA) entry <= ram_dout;
      if (state == BUS && (wb_ack_i || timed_out)) begin
        if (timed_out)      result <= 32'hDEAD_BEEF;
        else if (entry[40]) result <= wb_dat_i;
        else                result <= entry[31:0];
      end
      // Move on after an empty slot or after a retired command.
      if ((state == RD_DATA && !ram_dout[41]) || state == WRBACK)
        slot <= (slot == 5'(SLOTS - 1)) ? 5'd0 : slot + 5'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_adr_o  = '0;
    wb_dat_o  = '0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (scan_en) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        ram_en    = 1'b1;
        ram_addr  = slot;
        state_nxt = RD_DATA;
      end
      RD_DATA: begin
        state_nxt = ram_dout[41] ? BUS : IDLE;
      end
      BUS: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = ~entry[40];
        wb_adr_o = entry[39:32];
        wb_dat_o = entry[40] ? 32'd0 : entry[31:0];
        if (wb_ack_i || timed_out) state_nxt = WRBACK;
      end
      WRBACK: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = slot;
        ram_din   = {1'b0, entry[40:32], result};
        done      = ~to_flag;
        err       = to_flag;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mbox_wb_master.sv
// tb_mbox_wb_master: directed bench for mbox_wb_master with a behavioural
// mailbox RAM and a Wishbone slave with programmable ack delay.
// Runs in both builds; the timeout scenario adapts to MBOX_WB_TIMEOUT_EN.
module tb_mbox_wb_master;
  logic        clk = 1'b0;
  logic        rst, scan_en;
  logic        ram_en, ram_we;
  logic [4:0]  ram_addr;
  logic [41:0] ram_din, ram_dout;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_ack_i = 1'b0;
  logic        busy, done, err;

  always #5 clk = ~clk;

  mbox_wb_master #(.SLOTS(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .busy(busy), .done(done), .err(err)
  );

  // Mailbox RAM: 1-cycle read latency, plus a preload/clear path for the bench.
  logic [41:0] mem [0:31];
  logic        pl_vld = 1'b0, pl_clr = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [41:0] pl_dat = '0;
  always @(posedge clk) begin
    if (ram_en && !ram_we) ram_dout <= mem[ram_addr];
    if (pl_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    if (pl_vld) mem[pl_addr] <= pl_dat;
  end

  // Wishbone slave: ack after ack_dly waiting cycles of a live strobe.
  logic ack_en = 1'b1;
  int   ack_dly = 0;
  int   wcnt = 0;
  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i && ack_en) begin
      if (wcnt >= ack_dly) wb_ack_i <= 1'b1;
      else                 wcnt <= wcnt + 1;
    end else begin
      wb_ack_i <= 1'b0;
      wcnt     <= 0;
    end
  end

  // Monitor: samples on the falling edge.
  int          cyc_no = 0;
  int          done_n = 0, err_n = 0, bus_n = 0, wr_n = 0, act_n = 0, busy_n = 0, cyc_hi_n = 0;
  logic        last_we = 1'b0;
  logic [7:0]  last_adr = '0;
  logic [31:0] last_dat = '0;
  int          rd_cyc [32];
  int          wr_cyc [32];
  logic [4:0]  wr_q [$];
  logic        first_pend = 1'b0;
  logic [4:0]  first_addr = '0;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  always @(negedge clk) begin
    if (done) done_n++;
    if (err) err_n++;
    if (wb_cyc_o) cyc_hi_n++;
    if (ram_en || wb_cyc_o) act_n++;
    if (busy) busy_n++;
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      bus_n++;
      last_we  = wb_we_o;
      last_adr = wb_adr_o;
      last_dat = wb_dat_o;
    end
    if (ram_en && !ram_we) rd_cyc[ram_addr] = cyc_no;
    if (ram_en && ram_we) begin
      wr_n++;
      wr_cyc[ram_addr] = cyc_no;
      wr_q.push_back(ram_addr);
    end
    if (rst) first_pend = 1'b1;
    else if (ram_en && first_pend) begin
      first_addr = ram_addr;
      first_pend = 1'b0;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] ent(input logic v, input logic rd, input logic [7:0] adr,
                                      input logic [31:0] dat);
    return {v, rd, adr, dat};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic preload(input logic [4:0] a, input logic [41:0] d);
    pl_addr = a;
    pl_dat  = d;
    pl_vld  = 1'b1;
    tick(1);
    pl_vld  = 1'b0;
  endtask

  task automatic clear_mem();
    pl_clr = 1'b1;
    tick(1);
    pl_clr = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && done_n < target; k++) tick(1);
    check(tag, 64'(done_n), 64'(target));
  endtask

  task automatic wait_cyc(input int budget, input string tag);
    for (int k = 0; k < budget && !wb_cyc_o; k++) tick(1);
    check(tag, 64'(wb_cyc_o), 64'd1);
  endtask

  task automatic stop_scan(input string tag);
    scan_en = 1'b0;
    for (int k = 0; k < 50 && busy; k++) tick(1);
    check(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int b_done, b_err, b_bus, b_wr, b_act, b_busy, b_cyc, b_q;

  initial begin
    rst = 1'b1; scan_en = 1'b0; wb_dat_i = '0;
    tick(2);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_cyc",    64'({wb_cyc_o, wb_stb_o}), 64'd0);
    check("rst_done",   64'({done, err}), 64'd0);
    clear_mem();
    rst = 1'b0;
    tick(1);

    // Bus write from slot 3, ack after 2 wait cycles.
    clear_mem();
    preload(5'd3, ent(1'b1, 1'b0, 8'h12, 32'hCAFE_0001));
    ack_dly = 2;
    b_done = done_n; b_bus = bus_n; b_wr = wr_n;
    do_reset();
    scan_en = 1'b1;
    wait_done(b_done + 1, 200, "s1_done_wait");
    stop_scan("s1_idle");
    check("s1_first_addr", 64'(first_addr), 64'd0);
    check("s1_bus_cnt",    64'(bus_n - b_bus), 64'd1);
    check("s1_we",         64'(last_we), 64'd1);
    check("s1_adr",        64'(last_adr), 64'h12);
    check("s1_dat",        64'(last_dat), 64'hCAFE_0001);
    check("s1_mem3",       64'(mem[3]), 64'(ent(1'b0, 1'b0, 8'h12, 32'hCAFE_0001)));
    check("s1_wr_cnt",     64'(wr_n - b_wr), 64'd1);
    check("s1_done_cnt",   64'(done_n - b_done), 64'd1);

    // Bus read from slot 0, zero-wait ack: writeback 4 cycles after RD_REQ.
    clear_mem();
    preload(5'd0, ent(1'b1, 1'b1, 8'h40, 32'd0));
    ack_dly = 0;
    wb_dat_i = 32'h1234_5678;
    b_done = done_n;
    do_reset();
    scan_en = 1'b1;
    wait_done(b_done + 1, 200, "s2_done_wait");
    stop_scan("s2_idle");
    check("s2_we",      64'(last_we), 64'd0);
    check("s2_adr",     64'(last_adr), 64'h40);
    check("s2_dat_o",   64'(last_dat), 64'd0);
    check("s2_mem0",    64'(mem[0]), 64'(ent(1'b0, 1'b1, 8'h40, 32'h1234_5678)));
    check("s2_latency", 64'(wr_cyc[0] - rd_cyc[0]), 64'd4);

    // Wrap: slots 15 and 0 become pending while the pointer is at 14.
    clear_mem();
    wb_dat_i = 32'hA5A5_0000;
    b_done = done_n;
    do_reset();
    scan_en = 1'b1;
    for (int k = 0; k < 100 && !(ram_en && !ram_we && ram_addr == 5'd14); k++) tick(1);
    check("s3_reach14", 64'(ram_addr), 64'd14);
    preload(5'd15, ent(1'b1, 1'b0, 8'h5F, 32'hF0F0_0015));
    preload(5'd0,  ent(1'b1, 1'b1, 8'h50, 32'd0));
    b_q = wr_q.size();
    wait_done(b_done + 2, 200, "s3_done_wait");
    stop_scan("s3_idle");
    check("s3_order0", 64'(wr_q[b_q]), 64'd15);
    check("s3_order1", 64'(wr_q[b_q + 1]), 64'd0);
    check("s3_mem15",  64'(mem[15]), 64'(ent(1'b0, 1'b0, 8'h5F, 32'hF0F0_0015)));
    check("s3_mem0",   64'(mem[0]), 64'(ent(1'b0, 1'b1, 8'h50, 32'hA5A5_0000)));

    // Reset while slot 7 is on the bus.
    clear_mem();
    preload(5'd7, ent(1'b1, 1'b0, 8'h77, 32'h7777_0007));
    ack_en = 1'b0;
    do_reset();
    scan_en = 1'b1;
    wait_cyc(100, "s4_bus_reached");
    check("s4_adr", 64'(wb_adr_o), 64'h77);
    tick(3);
    b_wr = wr_n;
    rst = 1'b1;
    #1;
    check("s4_rst_cyc",  64'({wb_cyc_o, wb_stb_o}), 64'd0);
    check("s4_rst_busy", 64'(busy), 64'd0);
    check("s4_rst_ram",  64'(ram_en), 64'd0);
    tick(2);
    check("s4_pending",  64'(mem[7][41]), 64'd1);
    check("s4_no_wr",    64'(wr_n - b_wr), 64'd0);
    ack_en = 1'b1;
    b_done = done_n;
    rst = 1'b0;
    wait_done(b_done + 1, 200, "s4_done_wait");
    stop_scan("s4_idle");
    check("s4_first_addr", 64'(first_addr), 64'd0);
    check("s4_mem7", 64'(mem[7]), 64'(ent(1'b0, 1'b0, 8'h77, 32'h7777_0007)));

    // No ack at all.
    clear_mem();
    preload(5'd2, ent(1'b1, 1'b0, 8'h22, 32'h0000_0055));
    ack_en = 1'b0;
    b_done = done_n; b_err = err_n; b_cyc = cyc_hi_n;
    do_reset();
    scan_en = 1'b1;
`ifdef MBOX_WB_TIMEOUT_EN
    for (int k = 0; k < 200 && err_n == b_err; k++) tick(1);
    stop_scan("s5_idle");
    check("s5_err_cnt",  64'(err_n - b_err), 64'd1);
    check("s5_done_cnt", 64'(done_n - b_done), 64'd0);
    check("s5_cyc_len",  64'(cyc_hi_n - b_cyc), 64'd8);
    check("s5_mem2",     64'(mem[2]), 64'(ent(1'b0, 1'b0, 8'h22, 32'hDEAD_BEEF)));
    ack_en = 1'b1;
`else
    wait_cyc(100, "s5_bus_reached");
    tick(40);
    check("s5_still_cyc", 64'(wb_cyc_o), 64'd1);
    check("s5_err_cnt",   64'(err_n - b_err), 64'd0);
    check("s5_done_cnt",  64'(done_n - b_done), 64'd0);
    check("s5_pending",   64'(mem[2][41]), 64'd1);
    ack_en = 1'b1;
    wait_done(b_done + 1, 50, "s5_done_wait");
    stop_scan("s5_idle");
    check("s5_mem2", 64'(mem[2]), 64'(ent(1'b0, 1'b0, 8'h22, 32'h0000_0055)));
`endif

    // All slots pending but scanning disabled.
    for (int i = 0; i < 16; i++) preload(5'(i), ent(1'b1, 1'b0, 8'(i), 32'(i)));
    scan_en = 1'b0;
    b_act = act_n; b_busy = busy_n; b_wr = wr_n;
    do_reset();
    tick(20);
    check("s6_activity", 64'(act_n - b_act), 64'd0);
    check("s6_busy",     64'(busy_n - b_busy), 64'd0);
    check("s6_mem5",     64'(mem[5]), 64'(ent(1'b1, 1'b0, 8'h05, 32'h5)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
